// File: rtl/instr_sequencer.sv
// Instruction fetch/execute cycle sequencer for the 8-bit CPU.
// Optional single-step control: define SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
    parameter bit RESET_HALTED = 1'b0,
    parameter int WAIT_MAX     = 0,
    parameter int WAIT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_req,
    input  logic       halt_sig,
    input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [7:0] ir,
    output logic       cycle,
    output logic       ncycle,
    output logic       exec,
    output logic       pc_inc,
    output logic       halted,
    output logic       bus_err
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC_A = 2'd1;
    localparam logic [1:0] EXEC_B = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [1:0]        state;
    logic [1:0]        nxt;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nxt;
    logic              wait_hit;
    logic              fetch_ok;
    logic              last_exec;

    assign mem_req   = (state == FETCH) || (state == EXEC_A && ir[7]);
    assign cycle     = (state == EXEC_B);
    assign ncycle    = ~cycle;
    assign exec      = (state == EXEC_A) || (state == EXEC_B);
    assign halted    = (state == HALT);
    assign fetch_ok  = (state == FETCH) && mem_ack;
    assign last_exec = (state == EXEC_A && !ir[7]) || (state == EXEC_B);
    assign wait_hit  = (WAIT_MAX != 0) && mem_req && !mem_ack
                       && (cnt == WAIT_LAST);

`ifdef SEQ_SINGLE_STEP_EN
    logic stepping;
    logic step_nxt;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            FETCH: begin
                if (wait_hit)
                    nxt = HALT;
                else if (mem_ack)
                    nxt = EXEC_A;
            end
            EXEC_A: begin
                if (ir[7]) begin
                    if (wait_hit)
                        nxt = HALT;
                    else if (mem_ack)
                        nxt = EXEC_B;
                end else begin
                    nxt = halt_sig ? HALT : FETCH;
                end
            end
            EXEC_B: nxt = halt_sig ? HALT : FETCH;
            HALT: begin
                if (!bus_err && run)
                    nxt = FETCH;
`ifdef SEQ_SINGLE_STEP_EN
                else if (!bus_err && step)
                    nxt = FETCH;
`endif
            end
            default: nxt = FETCH;
        endcase
`ifdef SEQ_SINGLE_STEP_EN
        // A stepped instruction always parks back in HALT
        if (stepping && last_exec)
            nxt = HALT;
`endif
    end

`ifdef SEQ_SINGLE_STEP_EN
    always_comb begin
        step_nxt = stepping && (nxt != HALT);
        if (state == HALT && !bus_err && !run && step)
            step_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stepping <= 1'b0;
        else
            stepping <= step_nxt;
    end
`endif

    // Wait count restarts whenever the state moves or the bus answers
    always_comb begin
        cnt_nxt = '0;
        if (nxt == state && mem_req && !mem_ack && WAIT_MAX != 0)
            cnt_nxt = cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET_HALTED ? HALT : FETCH;
            ir      <= 8'h00;
            pc_inc  <= 1'b0;
            bus_err <= 1'b0;
            cnt     <= '0;
        end else begin
            state  <= nxt;
            pc_inc <= fetch_ok;
            cnt    <= cnt_nxt;
            if (fetch_ok)
                ir <= mem_rdata;
            if (wait_hit)
                bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed vector bench for instr_sequencer (WAIT_MAX=4).
module tb_instr_sequencer;

    typedef struct {
        bit       rst;
        bit       ack;
        bit [7:0] rdata;
        bit       hs;
        bit       run;
        bit       step;
        bit       mr;
        bit [7:0] ir;
        bit       cyc;
        bit       ex;
        bit       pci;
        bit       hlt;
        bit       be;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic       halt_sig = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       mem_req;
    logic [7:0] ir;
    logic       cycle;
    logic       ncycle;
    logic       exec;
    logic       pc_inc;
    logic       halted;
    logic       bus_err;

    int applied = 0;
    int errors  = 0;
    int pulses  = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .RESET_HALTED(1'b0),
        .WAIT_MAX(4),
        .WAIT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .mem_req(mem_req),
        .halt_sig(halt_sig),
        .run(run),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .ir(ir),
        .cycle(cycle),
        .ncycle(ncycle),
        .exec(exec),
        .pc_inc(pc_inc),
        .halted(halted),
        .bus_err(bus_err)
    );

    function automatic vec_t mk(
        bit r, bit a, bit [7:0] d, bit h, bit rn, bit s,
        bit m, bit [7:0] i, bit c, bit e, bit p, bit hl, bit b);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.hs = h;
        v.run = rn; v.step = s; v.mr = m; v.ir = i;
        v.cyc = c; v.ex = e; v.pci = p; v.hlt = hl; v.be = b;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [14:0] got;
        logic [14:0] exp;
        rst = v.rst;
        mem_ack = v.ack;
        mem_rdata = v.rdata;
        halt_sig = v.hs;
        run = v.run;
        step = v.step;
        @(posedge clk);
        #1;
        got = {mem_req, ir, cycle, ncycle, exec, pc_inc, halted, bus_err};
        exp = {v.mr, v.ir, v.cyc, ~v.cyc, v.ex, v.pci, v.hlt, v.be};
        if (pc_inc)
            pulses++;
        applied++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got req=%b ir=%h cyc=%b ncyc=%b ex=%b pci=%b hlt=%b be=%b, want req=%b ir=%h cyc=%b ncyc=%b ex=%b pci=%b hlt=%b be=%b",
                name, got[14], got[13:6], got[5], got[4], got[3], got[2], got[1], got[0],
                exp[14], exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        applied++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        //                rst ack data hs run st  mr ir    cy ex pc hl be
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 8'h12, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h12, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h18, 0, 0, 0, 0, 8'h18, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h18, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0, 0, 8'h18, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 8'h18, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h18, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h18, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h18, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h18, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h18, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'h33, 0, 1, 0, 0, 8'h18, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC3, 0, 0, 0, 1, 8'hC3, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'hC3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h77, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h99, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h81, 0, 0, 0, 1, 8'h81, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'h81, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h81, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h81, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 8'h81, 0, 0, 0, 0, 0));

        #2;
        foreach (tbl[i])
            apply(tbl[i], $sformatf("v%0d", i));
        check_int("pc_inc_pulses_table", pulses, 5);

        // Back-to-back one-cycle instructions: two clocks each
        pulses = 0;
        apply(mk(0, 1, 8'h21, 0, 0, 0, 0, 8'h21, 0, 1, 1, 0, 0), "b2b_a1");
        apply(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h21, 0, 0, 0, 0, 0), "b2b_f");
        apply(mk(0, 1, 8'h22, 0, 0, 0, 0, 8'h22, 0, 1, 1, 0, 0), "b2b_a2");
        apply(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h22, 0, 0, 0, 0, 0), "b2b_f2");
        check_int("pc_inc_pulses_b2b", pulses, 2);

`ifdef SEQ_SINGLE_STEP_EN
        apply(mk(0, 1, 8'h01, 0, 0, 0, 0, 8'h01, 0, 1, 1, 0, 0), "st_fetch");
        apply(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h01, 0, 0, 0, 1, 0), "st_halt");
        pulses = 0;
        apply(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h01, 0, 0, 0, 0, 0), "st_go");
        apply(mk(0, 1, 8'h05, 0, 0, 0, 0, 8'h05, 0, 1, 1, 0, 0), "st_exec");
        apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h05, 0, 0, 0, 1, 0), "st_back");
        apply(mk(0, 1, 8'h06, 0, 0, 0, 0, 8'h05, 0, 0, 0, 1, 0), "st_park");
        check_int("st_pc_inc_pulses", pulses, 1);
        apply(mk(0, 0, 8'h00, 0, 1, 1, 1, 8'h05, 0, 0, 0, 0, 0), "st_runpri");
        apply(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h02, 0, 1, 1, 0, 0), "st_run_a");
        apply(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h02, 0, 0, 0, 0, 0), "st_run_f");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
